riskv_dmem_wb_bridge: RTL and testbench
=======================================

// Module: riskv_dmem_wb_bridge
// PURPOSE
//  Downstream neighbour of the rv32i core's data port (mem_d_*). Converts the core's
//  single-cycle strobe / busy-freeze protocol into Wishbone B4 classic cycles.
//  One outstanding access; busy freezes the core pipeline until the access completes.
//  Read data is held stable for the core's write-back stage.
// PARAMETERS
//  AW              32             byte-address width on the core side; wb_adr_o is AW-2 bits (word address)
//  TIMEOUT_CYCLES  255            bus-watchdog limit in BUS state; used only with RISKV_DBRIDGE_TIMEOUT_EN
//  ERR_RDATA       32'hFFFF_FFFF  value returned to the core on a failed read
// PORTS
//  clk           in   1     single clock; all logic rising-edge
//  rst_n         in   1     synchronous reset, active-low
//  mem_d_addr    in   AW    byte address from core
//  mem_d_wdata   in   32    store data, already lane-replicated by core
//  mem_d_wmask   in   4     byte enables for stores
//  mem_d_wstrb   in   1     store request, held high while frozen
//  mem_d_rstrb   in   1     load request, held high while frozen
//  mem_d_rdata   out  32    load data, registered
//  mem_d_rbusy   out  1     load in progress (combinational)
//  mem_d_wbusy   out  1     store in progress (combinational)
//  wb_cyc_o/wb_stb_o out 1  Wishbone cycle/strobe, registered, always equal
//  wb_we_o       out  1     1 = write
//  wb_adr_o      out  AW-2  mem_d_addr[AW-1:2]
//  wb_sel_o      out  4     wmask for writes, 4'b1111 for reads
//  wb_dat_o      out  32    write data
//  wb_dat_i      in   32    read data
//  wb_ack_i      in   1     cycle completed OK
//  wb_err_i      in   1     cycle completed with error
//  bus_err       out  1     sticky error flag; cleared only by reset
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; cyc/stb/we=0; adr/sel/dat_o=0; mem_d_rdata=0; bus_err=0.
//    rbusy/wbusy are forced 0 while rst_n=0. Reset mid-cycle drops cyc/stb at that edge; the pending ack is ignored.
//  - FSM IDLE -> BUS -> DONE -> IDLE.
//    IDLE: on wstrb|rstrb, latch addr/wdata/sel/we (wstrb wins if both are high; the read is dropped).
//      Go to BUS with cyc/stb=1 next cycle.
//      Exception: wstrb with wmask==0 goes directly to DONE; no bus cycle occurs.
//    BUS: hold all wb outputs stable.
//      On ack: capture wb_dat_i into mem_d_rdata (reads only), drop cyc/stb, go to DONE.
//      On err: same transition; reads return ERR_RDATA; set bus_err.
//      ack and err together count as err.
//    DONE: one cycle; busy deasserts so the core advances; go to IDLE.
//  - Busy: mem_d_rbusy = rstrb && state!=DONE. mem_d_wbusy = wstrb && state!=DONE.
//    Both are 0 in DONE, so the strobe seen in DONE never restarts a cycle.
//  - Latency: zero-wait ack gives 3 cycles of strobe (IDLE, BUS, DONE). Each wait state adds 1 cycle.
//  - mem_d_rdata changes only on read completion; it holds through writes and idle periods.
//  - Back-to-back: a strobe in the cycle after DONE starts a new access from IDLE.
// CONFIGURATION
//  RISKV_DBRIDGE_TIMEOUT_EN defined:
//    - An 8+ bit counter clears on entry to BUS and increments each BUS cycle.
//    - When the count reaches TIMEOUT_CYCLES without ack/err: drop cyc/stb, go to DONE, set bus_err; reads return ERR_RDATA.
//    - An ack arriving on the same cycle as expiry wins.
//  Not defined: no counter; BUS waits indefinitely for ack/err; TIMEOUT_CYCLES is unused.
// TESTING
//  - Read, ack after 2 waits:
//    rstrb @0x100, wb_dat_i=32'h1234_5678 -> adr=0x40, sel=F, we=0.
//    rbusy high for 4 cycles, then low for 1; rdata=1234_5678 and held after strobe drops.
//  - Byte store:
//    wstrb, addr 0x203, wmask=4'b1000, wdata=AAAAAAAA, zero-wait ack -> sel=8, we=1, dat_o=AAAAAAAA.
//    wbusy high for exactly 2 cycles; rdata unchanged.
//  - Error read:
//    wb_err_i on first BUS cycle -> rdata=FFFF_FFFF; bus_err=1 and stays 1 through later good accesses.
//  - Zero-mask store:
//    wstrb, wmask=0 -> cyc never asserts; wbusy high for 1 cycle.
//  - Reset mid-BUS:
//    rst_n=0 during a waited read -> next cycle cyc=0, rdata=0, bus_err=0.
//    A late ack after reset has no effect.
//  - Timeout (macro on, TIMEOUT_CYCLES=4):
//    no ack -> cyc drops after 4 BUS cycles; bus_err=1; rdata=ERR_RDATA.
//    Macro off: the bridge is still in BUS after 1000 cycles.

Source files
------------

// File: rtl/riskv_dmem_wb_bridge.sv
// riskv_dmem_wb_bridge: rv32i data-port to Wishbone B4 classic bridge.
// Carries one access at a time. The core's strobe is frozen by busy until the
// bus cycle completes. Read data is registered and held for write-back.
// Optional bus watchdog: define RISKV_DBRIDGE_TIMEOUT_EN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; a strobe latches the request
// BUS   | Wishbone cycle open; waiting for ack/err (or watchdog expiry)
// DONE  | access finished; busy low for one cycle so the core advances
module riskv_dmem_wb_bridge #(
  parameter int          AW             = 32,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] mem_d_addr,
  input  logic [31:0]   mem_d_wdata,
  input  logic [3:0]    mem_d_wmask,
  input  logic          mem_d_wstrb,
  input  logic          mem_d_rstrb,
  output logic [31:0]   mem_d_rdata,
  output logic          mem_d_rbusy,
  output logic          mem_d_wbusy,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-3:0] wb_adr_o,
  output logic [3:0]    wb_sel_o,
  output logic [31:0]   wb_dat_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic          bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t state, state_nxt;
  logic   cyc_q;
  logic   req_go;
  logic   fin;
  logic   fin_err;
  logic   to_hit;

  // Byte offset within a word is carried by wb_sel_o, not the address.
  logic unused_addr;
  assign unused_addr = ^mem_d_addr[1:0];

`ifdef RISKV_DBRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] to_cnt;

  assign to_hit = (state == BUS) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts BUS cycles, held at zero outside BUS.
  always_ff @(posedge clk) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state != BUS)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + CW'(1);
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  // Next state and completion decode; err outranks ack, ack outranks expiry.
  always_comb begin
    state_nxt = state;
    req_go    = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_d_wstrb || mem_d_rstrb) begin
          req_go    = 1'b1;
          state_nxt = (mem_d_wstrb && (mem_d_wmask == 4'b0000)) ? DONE : BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = DONE;
        end else if (wb_ack_i) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end else if (to_hit) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latch, read-data capture and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc_q       <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= 4'b0000;
      wb_dat_o    <= 32'h0;
      mem_d_rdata <= 32'h0;
      bus_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc_q <= (state_nxt == BUS);
      if (req_go) begin
        wb_we_o  <= mem_d_wstrb;
        wb_adr_o <= mem_d_addr[AW-1:2];
        wb_sel_o <= mem_d_wstrb ? mem_d_wmask : 4'b1111;
        wb_dat_o <= mem_d_wdata;
      end
      if (fin && !wb_we_o)
        mem_d_rdata <= fin_err ? ERR_RDATA : wb_dat_i;
      if (fin_err)
        bus_err <= 1'b1;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

  // Busy drops in DONE so the still-high strobe cannot re-launch the access.
  assign mem_d_rbusy = rst_n && mem_d_rstrb && (state != DONE);
  assign mem_d_wbusy = rst_n && mem_d_wstrb && (state != DONE);

endmodule

// File: tb/tb_riskv_dmem_wb_bridge.sv
// Bench for riskv_dmem_wb_bridge: directed spec cases plus randomized accesses
// against a transaction-level model (busy length, bus window, rdata, bus_err).
module tb_riskv_dmem_wb_bridge;

  localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_d_addr;
  logic [31:0] mem_d_wdata;
  logic [3:0]  mem_d_wmask;
  logic        mem_d_wstrb;
  logic        mem_d_rstrb;
  logic [31:0] mem_d_rdata;
  logic        mem_d_rbusy;
  logic        mem_d_wbusy;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rdata_m;
  logic        berr_m;

  always #5 clk = ~clk;

  riskv_dmem_wb_bridge #(
    .AW(32),
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA(ERR_VAL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_d_addr(mem_d_addr),
    .mem_d_wdata(mem_d_wdata),
    .mem_d_wmask(mem_d_wmask),
    .mem_d_wstrb(mem_d_wstrb),
    .mem_d_rstrb(mem_d_rstrb),
    .mem_d_rdata(mem_d_rdata),
    .mem_d_rbusy(mem_d_rbusy),
    .mem_d_wbusy(mem_d_wbusy),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .bus_err(bus_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One core access. The slave acks on BUS cycle 'waits' (0 = zero-wait).
  // Expected: busy for IDLE + (waits+1) BUS cycles, or 1 cycle for a zero-mask store.
  task automatic do_access(input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] m,
                           input int waits, input bit err, input bit both_ae,
                           input logic [31:0] rd, input bit gap);
    bit          zero;
    bit          in_bus;
    int          nb;
    int          bus_cnt;
    logic [31:0] rdata_new;
    logic        berr_new;
    zero      = w && (m == 4'b0000);
    nb        = zero ? 1 : waits + 2;
    bus_cnt   = 0;
    rdata_new = (!w) ? (err ? ERR_VAL : rd) : rdata_m;
    berr_new  = berr_m || (err && !zero);
    for (int c = 0; c <= nb; c++) begin
      @(negedge clk);
      mem_d_wstrb = w;
      mem_d_rstrb = r;
      mem_d_addr  = a;
      mem_d_wdata = wd;
      mem_d_wmask = m;
      wb_ack_i    = 1'b0;
      wb_err_i    = 1'b0;
      wb_dat_i    = $urandom;
      if (wb_cyc_o) begin
        if (bus_cnt == waits) begin
          if (err) begin
            wb_err_i = 1'b1;
            wb_ack_i = both_ae;
          end else begin
            wb_ack_i = 1'b1;
          end
          wb_dat_i = rd;
        end
        bus_cnt++;
      end
      #1;
      in_bus = !zero && (c >= 1) && (c <= waits + 1);
      check_eq("rbusy", mem_d_rbusy, r && (c < nb));
      check_eq("wbusy", mem_d_wbusy, w && (c < nb));
      check_eq("cyc", wb_cyc_o, in_bus);
      check_eq("stb", wb_stb_o, in_bus);
      check_eq("rdata", mem_d_rdata, (c == nb) ? rdata_new : rdata_m);
      check_eq("bus_err", bus_err, (c == nb) ? berr_new : berr_m);
      if (in_bus) begin
        check_eq("we", wb_we_o, w);
        check_eq("adr", wb_adr_o, a[31:2]);
        check_eq("sel", wb_sel_o, w ? m : 4'b1111);
        if (w) check_eq("dat_o", wb_dat_o, wd);
      end
    end
    rdata_m = rdata_new;
    berr_m  = berr_new;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (gap) begin
      @(negedge clk);
      mem_d_wstrb = 1'b0;
      mem_d_rstrb = 1'b0;
      #1;
      check_eq("idle_cyc", wb_cyc_o, 1'b0);
      check_eq("idle_busy", {mem_d_rbusy, mem_d_wbusy}, 2'b00);
      check_eq("idle_rdata", mem_d_rdata, rdata_m);
    end
  endtask

  task automatic random_accesses(input int n);
    int          kind;
    bit          w;
    bit          r;
    logic [3:0]  m;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      w    = (kind != 0);
      r    = (kind == 0) || (kind == 2);
      m    = (kind == 3) ? 4'b0000 : (w ? 4'($urandom_range(1, 15)) : 4'($urandom));
      do_access(w, r, $urandom, $urandom, m, $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0), 1'($urandom), $urandom, 1'($urandom));
    end
  endtask

  initial begin
    int  n_bus;
    bit  dropped;
    rst_n       = 1'b0;
    mem_d_addr  = '0;
    mem_d_wdata = '0;
    mem_d_wmask = '0;
    mem_d_wstrb = 1'b0;
    mem_d_rstrb = 1'b0;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    rdata_m     = 32'h0;
    berr_m      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, bus_err}, 8'h00);
    check_eq("rst_adr", wb_adr_o, 30'h0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    check_eq("rst_rdata", mem_d_rdata, 32'h0);
    rst_n = 1'b1;

    // Directed cases
    do_access(1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 2, 1'b0, 1'b0, 32'h1234_5678, 1'b1);
    do_access(1'b1, 1'b0, 32'h203, 32'hAAAA_AAAA, 4'b1000, 0, 1'b0, 1'b0, 32'h0, 1'b1);
    do_access(1'b0, 1'b1, 32'h44, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'h5555_0000, 1'b1);
    do_access(1'b0, 1'b1, 32'h48, 32'h0, 4'h0, 1, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0);
    do_access(1'b1, 1'b0, 32'h4C, 32'h1111_2222, 4'b0000, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_access(1'b1, 1'b1, 32'h50, 32'h3333_4444, 4'b0011, 1, 1'b0, 1'b0, 32'h9999_9999, 1'b1);

    random_accesses(150);

    // Reset during a waited read
    @(negedge clk);
    mem_d_rstrb = 1'b1;
    mem_d_wstrb = 1'b0;
    mem_d_addr  = 32'h600;
    repeat (2) @(negedge clk);
    #1;
    check_eq("pre_rst_cyc", wb_cyc_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_rbusy_forced", mem_d_rbusy, 1'b0);
    @(negedge clk);
    check_eq("rst_mid_cyc", wb_cyc_o, 1'b0);
    check_eq("rst_mid_rdata", mem_d_rdata, 32'h0);
    check_eq("rst_mid_berr", bus_err, 1'b0);
    rst_n       = 1'b1;
    mem_d_rstrb = 1'b0;
    wb_ack_i    = 1'b1;
    wb_dat_i    = 32'hDEAD_BEEF;
    @(negedge clk);
    wb_ack_i = 1'b0;
    #1;
    check_eq("late_ack_cyc", wb_cyc_o, 1'b0);
    check_eq("late_ack_rdata", mem_d_rdata, 32'h0);
    check_eq("late_ack_busy", mem_d_rbusy, 1'b0);
    rdata_m = 32'h0;
    berr_m  = 1'b0;

    random_accesses(30);

    // Unanswered read: watchdog or indefinite wait
    @(negedge clk);
    mem_d_rstrb = 1'b1;
    mem_d_wstrb = 1'b0;
    mem_d_addr  = 32'h700;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    n_bus       = 0;
    dropped     = 1'b0;
`ifdef RISKV_DBRIDGE_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      #1;
      if (wb_cyc_o) n_bus++;
      if (!mem_d_rbusy) begin
        dropped = 1'b1;
        break;
      end
      @(negedge clk);
    end
    mem_d_rstrb = 1'b0;
    check_eq("to_done", dropped, 1'b1);
    check_eq("to_bus_cycles", n_bus, 4);
    check_eq("to_berr", bus_err, 1'b1);
    check_eq("to_rdata", mem_d_rdata, ERR_VAL);
    @(negedge clk);
    check_eq("to_cyc_after", wb_cyc_o, 1'b0);
`else
    repeat (1000) @(negedge clk);
    #1;
    check_eq("no_to_cyc", wb_cyc_o, 1'b1);
    check_eq("no_to_rbusy", mem_d_rbusy, 1'b1);
    check_eq("no_to_berr", bus_err, berr_m);
    mem_d_rstrb = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
